// File: rtl/mul_exec_stage.sv
// Two-stage multiply execute unit: an operand register (E) drives the combinational
// intMul array, and a result register (W) returns one or two 32-bit beats per op.

module intMul (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        us_i,
  output logic [63:0] p_o
);
  logic signed [65:0] a_x_s;
  logic signed [65:0] b_x_s;
  logic signed [65:0] prod_s;

  // us=1 treats both operands as signed; otherwise they are zero-extended
  assign a_x_s  = {{34{us_i & a_i[31]}}, a_i};
  assign b_x_s  = {{34{us_i & b_i[31]}}, b_i};
  assign prod_s = a_x_s * b_x_s;
  assign p_o    = prod_s[63:0];
endmodule

module mul_exec_stage #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_last,
  output logic             busy
);
  typedef enum logic [1:0] {
    OP_MULL  = 2'b00,
    OP_MULH  = 2'b01,
    OP_MULHU = 2'b10,
    OP_MUL64 = 2'b11
  } op_e;

  function automatic logic op_us(input logic [1:0] op);
    logic us;
    case (op)
      OP_MULH, OP_MUL64: us = 1'b1;
      default:           us = 1'b0;
    endcase
    return us;
  endfunction

  logic             e_valid_q, e_valid_d;
  logic [1:0]       e_op_q, e_op_d;
  logic [TAG_W-1:0] e_tag_q, e_tag_d;
  logic [31:0]      e_a_q, e_a_d, e_b_q, e_b_d;
  logic             w_valid_q, w_valid_d;
  logic [1:0]       w_op_q, w_op_d;
  logic [TAG_W-1:0] w_tag_q, w_tag_d;
  logic [31:0]      w_oh_q, w_oh_d, w_ol_q, w_ol_d;
  logic             beat_q, beat_d;

  logic [63:0] prod_s;
  logic        w_last_s, out_hs_s, w_done_s, e_adv_s, in_fire_s;

  intMul u_mul (
    .a_i  (e_a_q),
    .b_i  (e_b_q),
    .us_i (op_us(e_op_q)),
    .p_o  (prod_s)
  );

  // Handshake terms; a flush-cycle handshake is ignored so nothing moves on a kill
  assign w_last_s  = ~((w_op_q == OP_MUL64) & ~beat_q);
  assign out_hs_s  = w_valid_q & out_ready & ~flush;
  assign w_done_s  = out_hs_s & w_last_s;
  assign e_adv_s   = e_valid_q & (~w_valid_q | w_done_s) & ~flush;
  assign in_ready  = ~flush & (~e_valid_q | e_adv_s);
  assign in_fire_s = in_valid & in_ready;
  assign out_valid = w_valid_q;
  assign busy      = e_valid_q | w_valid_q;

  // Result word selection, gated to zero while no beat is presented
  always_comb begin
    out_data = 32'h0000_0000;
    out_tag  = {TAG_W{1'b0}};
    out_last = 1'b0;
    if (w_valid_q) begin
      out_tag  = w_tag_q;
      out_last = w_last_s;
      case (w_op_q)
        OP_MULL:  out_data = w_ol_q;
        OP_MUL64: out_data = beat_q ? w_oh_q : w_ol_q;
        default:  out_data = w_oh_q;
      endcase
    end else begin
      out_data = 32'h0000_0000;
    end
  end

  // Next-state for both pipeline stages
  always_comb begin
    e_valid_d = e_valid_q;
    e_op_d    = e_op_q;
    e_tag_d   = e_tag_q;
    e_a_d     = e_a_q;
    e_b_d     = e_b_q;
    w_valid_d = w_valid_q;
    w_op_d    = w_op_q;
    w_tag_d   = w_tag_q;
    w_oh_d    = w_oh_q;
    w_ol_d    = w_ol_q;
    beat_d    = beat_q;
    if (flush) begin
      e_valid_d = 1'b0;
      w_valid_d = 1'b0;
      beat_d    = 1'b0;
    end else begin
      if (e_adv_s) begin
        w_valid_d = 1'b1;
        w_op_d    = e_op_q;
        w_tag_d   = e_tag_q;
        w_oh_d    = prod_s[63:32];
        w_ol_d    = prod_s[31:0];
        beat_d    = 1'b0;
      end else if (w_done_s) begin
        w_valid_d = 1'b0;
        beat_d    = 1'b0;
      end else if (out_hs_s) begin
        beat_d    = 1'b1;
      end else begin
        beat_d    = beat_q;
      end
      if (in_fire_s) begin
        e_valid_d = 1'b1;
        e_op_d    = in_op;
        e_tag_d   = in_tag;
        e_a_d     = in_a;
        e_b_d     = in_b;
      end else if (e_adv_s) begin
        e_valid_d = 1'b0;
      end else begin
        e_valid_d = e_valid_q;
      end
    end
  end

  // Pipeline state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_valid_q <= 1'b0;
      e_op_q    <= 2'b00;
      e_tag_q   <= {TAG_W{1'b0}};
      e_a_q     <= 32'h0000_0000;
      e_b_q     <= 32'h0000_0000;
      w_valid_q <= 1'b0;
      w_op_q    <= 2'b00;
      w_tag_q   <= {TAG_W{1'b0}};
      w_oh_q    <= 32'h0000_0000;
      w_ol_q    <= 32'h0000_0000;
      beat_q    <= 1'b0;
    end else begin
      e_valid_q <= e_valid_d;
      e_op_q    <= e_op_d;
      e_tag_q   <= e_tag_d;
      e_a_q     <= e_a_d;
      e_b_q     <= e_b_d;
      w_valid_q <= w_valid_d;
      w_op_q    <= w_op_d;
      w_tag_q   <= w_tag_d;
      w_oh_q    <= w_oh_d;
      w_ol_q    <= w_ol_d;
      beat_q    <= beat_d;
    end
  end
endmodule

// File: tb/tb_mul_exec_stage.sv
// Bench for mul_exec_stage: directed scenarios plus random traffic, checked every
// cycle against a queue of expected result beats computed with plain arithmetic.

module tb_mul_exec_stage;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       in_op = 2'b00;
  logic [TAG_W-1:0] in_tag = '0;
  logic [31:0]      in_a = 32'h0;
  logic [31:0]      in_b = 32'h0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_last;
  logic             busy;

  mul_exec_stage #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_tag(in_tag),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    logic             last;
    int               acc;
  } beat_t;

  beat_t q[$];
  int    n_chk = 0;
  int    n_pass = 0;
  int    iter = 0;
  bit    acc_seen, hs_seen, hs_last, bp_mode;
  bit    pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, iter);
  endtask

  task automatic push(input logic [31:0] d, input logic [TAG_W-1:0] t, input logic l);
    beat_t b;
    b.data = d; b.tag = t; b.last = l; b.acc = iter;
    q.push_back(b);
  endtask

  // Reference products from integer arithmetic on the architectural op meanings
  task automatic model_op(input logic [1:0] op, input logic [TAG_W-1:0] t,
                          input logic [31:0] a, input logic [31:0] b);
    longint      ps;
    logic [63:0] sv, uv;
    ps = longint'(int'(a)) * longint'(int'(b));
    sv = ps;
    uv = {32'h0, a} * {32'h0, b};
    case (op)
      2'b00:   push(uv[31:0], t, 1'b1);
      2'b01:   push(sv[63:32], t, 1'b1);
      2'b10:   push(uv[63:32], t, 1'b1);
      default: begin push(sv[31:0], t, 1'b0); push(sv[63:32], t, 1'b1); end
    endcase
  endtask

  // One cycle: inputs are already driven at the falling edge
  task automatic step();
    int   ops;
    bit   vis;
    logic exp_rdy;
    if (bp_mode) out_ready = pat[iter % 6];
    #1;
    ops = 0;
    foreach (q[i]) if (q[i].last) ops++;
    vis = (q.size() > 0) && (iter - q[0].acc >= 2);
    check("out_valid", out_valid, vis);
    check("busy", busy, ops > 0);
    if (vis) begin
      check("out_data", out_data, q[0].data);
      check("out_tag", out_tag, q[0].tag);
      check("out_last", out_last, q[0].last);
    end else begin
      check("gated_data", out_data, 64'h0);
      check("gated_tag", out_tag, 64'h0);
      check("gated_last", out_last, 64'h0);
    end
    exp_rdy = !flush && (ops < 2 || (vis && out_ready && q[0].last));
    check("in_ready", in_ready, exp_rdy);
    acc_seen = 1'b0; hs_seen = 1'b0; hs_last = 1'b0;
    if (flush) begin
      q.delete();
    end else begin
      if (vis && out_ready) begin
        hs_seen = 1'b1; hs_last = q[0].last;
        void'(q.pop_front());
      end
      if (in_valid && in_ready) begin
        acc_seen = 1'b1;
        model_op(in_op, in_tag, in_a, in_b);
      end
    end
    iter++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic [1:0] op, input logic [TAG_W-1:0] t,
                       input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1; in_op = op; in_tag = t; in_a = a; in_b = b;
    for (int i = 0; i < 60; i++) begin
      step();
      if (acc_seen) break;
    end
    if (!acc_seen) check("issue_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (q.size() == 0) break;
      step();
    end
    check("drain_empty", q.size(), 64'd0);
    step();
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] corner [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 4)];
    return $urandom();
  endfunction

  initial begin
    // Reset state
    #1;
    check("rst_out_valid", out_valid, 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_busy", busy, 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();

    // MULL then MULH/MULHU back-to-back
    issue(2'b00, 5'd3, 32'd7, 32'd6);
    drain();
    issue(2'b01, 5'd4, 32'hFFFF_FFFF, 32'd2);
    issue(2'b10, 5'd5, 32'hFFFF_FFFF, 32'd2);
    drain();

    // MUL64 followed by a MULL that must see one bubble
    issue(2'b11, 5'd6, 32'h8000_0000, 32'h8000_0000);
    issue(2'b00, 5'd7, 32'd9, 32'd9);
    drain();

    // Backpressure with mixed ops
    bp_mode = 1'b1;
    for (int i = 0; i < 6; i++)
      issue(2'(i % 4), 5'(10 + i), pick_operand(), pick_operand());
    for (int i = 0; i < 40; i++) begin
      if (q.size() == 0) break;
      step();
    end
    bp_mode = 1'b0;
    drain();

    // Flush with both stages full and a new op presented
    out_ready = 1'b0;
    issue(2'b00, 5'd20, 32'd3, 32'd5);
    issue(2'b01, 5'd21, 32'd11, 32'd13);
    flush = 1'b1; in_valid = 1'b1; in_op = 2'b00; in_tag = 5'd22; in_a = 32'd2; in_b = 32'd2;
    step();
    flush = 1'b0; in_valid = 1'b0;
    step();
    out_ready = 1'b1;
    issue(2'b10, 5'd23, 32'hDEAD_BEEF, 32'h1234_5678);
    drain();

    // Async reset between MUL64 beats
    issue(2'b11, 5'd24, 32'h8000_0000, 32'h8000_0000);
    for (int i = 0; i < 10; i++) begin
      step();
      if (hs_seen) break;
    end
    check("mul64_lo_seen", {hs_seen, hs_last}, 64'd2);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 64'd0);
    check("arst_out_data", out_data, 64'd0);
    check("arst_busy", busy, 64'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    issue(2'b00, 5'd25, 32'd100, 32'd3);
    drain();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 9) < 6);
      in_op     = 2'($urandom_range(0, 3));
      in_tag    = TAG_W'($urandom());
      in_a      = pick_operand();
      in_b      = pick_operand();
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 31) == 0);
      step();
    end
    flush = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mul_exec_stage.md
# mul_exec_stage

- Pipelined, handshaked execute stage wrapping the combinational `intMul` array.
- Accepts multiply ops from issue, registers operands, drives `intMul`, and registers the 64-bit product.
- Returns 32-bit results to writeback in order, one or two beats per op.
- Sits between the issue queue and the register-file writeback arbiter.

## Interface
Parameters:
- `TAG_W`, 5, width of the destination tag carried with each op.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous kill of all in-flight ops.
- `in_valid`  in  1  issue presents an op.
- `in_ready`  out  1  stage accepts the op this cycle.
- `in_op`  in  2  operation code:
  - 00 MULL: low word; `us`=0.
  - 01 MULH: high word, signed×signed; `us`=1.
  - 10 MULHU: high word, unsigned; `us`=0.
  - 11 MUL64: signed, two beats, low word then high word; `us`=1.
- `in_tag`  in  TAG_W  destination tag.
- `in_a`, `in_b`  in  32 each  operands.
- `out_valid`  out  1  result beat available.
- `out_ready`  in  1  writeback takes the beat.
- `out_data`  out  32  result word.
- `out_tag`  out  TAG_W  tag of the beat.
- `out_last`  out  1  final beat of the op.
- `busy`  out  1  any stage valid.

## Operation
- **Stage E** (operand register): `e_valid`, op, tag, A, B.
  - Drives `intMul` with A, B and the `us` mapping per op.
- **Stage W** (result register): `w_valid`, op, tag, OH, OL, 1-bit `beat`.
- **Output select:**
  - MULL → OL.
  - MULH and MULHU → OH.
  - MUL64 → OL when `beat`=0, OH when `beat`=1.
- **`out_last`:** 1 except for MUL64 with `beat`=0.
- **Gating:** `out_data`, `out_tag` and `out_last` are forced to 0 whenever `out_valid`=0.
- **W completes:** when `out_valid & out_ready & out_last`.
- **MUL64 first beat:** a handshake with `out_last`=0 sets `beat`=1. W keeps the op and E does not advance.
- **W load:** W loads from E when `e_valid` and (W empty or W completes this cycle); `beat` is cleared to 0.
- **E load:** E loads from input when `in_valid & in_ready`.
- **`in_ready`:** `!e_valid | (E advances this cycle)`, and is 0 during `flush`.
  - Combinational path from `out_ready` to `in_ready` is permitted; no skid buffer.
- **`flush`:** next edge clears `e_valid`, `w_valid`, `beat`.
  - An op presented in a flush cycle is not accepted.
  - `out_valid` may be high during the flush cycle, but any handshake in that cycle is ignored by the core (writeback also sees the flush).
- **Ordering:** ops complete strictly in acceptance order; no reordering, no drops, no duplication.
- **`busy`:** `e_valid | w_valid`.

## Timing
- **Reset state** (asynchronous, immediate on `rst_n`=0): `e_valid`=0, `w_valid`=0, `beat`=0, all data/tag registers 0.
  - Hence `out_valid`=0, `out_data`=0, `out_tag`=0, `out_last`=0, `busy`=0, `in_ready`=1 (once `rst_n`=1).
- **Latency:** op accepted at edge N → result visible (`out_valid`=1) after edge N+2.
  - The MUL64 high beat is visible the cycle after the low-beat handshake.
- **Throughput:** one single-beat op per cycle with `out_ready` held 1. MUL64 occupies W for 2 cycles, creating one bubble upstream.
- **`intMul` timing:** the combinational path is E → `intMul` → W in one cycle; no multicycle path.
- **Backpressure:**
  - W holds indefinitely while `out_ready`=0.
  - E holds while W cannot drain.
  - Both full with `out_ready`=0 → `in_ready`=0.
- **Simultaneous events:**
  - Input accept and E→W transfer in the same cycle is legal.
  - `flush` overrides all loads.
  - Reset overrides `flush`.
- **Reset mid-MUL64** (after the low beat): the high beat never appears.

## Test plan
- **MULL:** `in_op`=00, A=7, B=6, tag=3, `out_ready`=1 → two cycles after accept: `out_data`=42, `out_tag`=3, `out_last`=1, one beat only.
- **MULH vs MULHU:** A=0xFFFFFFFF, B=2.
  - MULH → `out_data`=0xFFFFFFFF.
  - MULHU → `out_data`=0x00000001.
  - Ops issued back-to-back, results on consecutive cycles.
- **MUL64:** A=B=0x80000000.
  - Beat 0: `out_data`=0x00000000, `out_last`=0.
  - Next cycle, beat 1: `out_data`=0x40000000, `out_last`=1, same tag.
  - A MULL issued behind it sees exactly one bubble.
- **Backpressure:** 6 mixed ops with `out_ready` pattern 1,0,0,1,0,1,… → all results in order with correct tags, none lost or duplicated; `in_ready`=0 whenever E and W are full and `out_ready`=0.
- **Flush:** E and W both full, `flush` pulsed one cycle with a new `in_valid` op → next cycle `out_valid`=0, `busy`=0; the flushed-cycle op is never output; the following op completes normally.
- **Async reset:** assert `rst_n`=0 between the MUL64 beats → `out_valid`=0 and `out_data`=0 immediately; after release, no stale beat appears and the first new op completes with 2-cycle latency.
